// File: rtl/code_conv_pkg.sv
// ---------------------------------------------------------------------------
// code_conv_pkg
// Shared types and helpers for the binary<->Gray conversion arbiter.
//   MODE_B2G / MODE_G2B : per-request operation select
//   state_t             : engine FSM state (IDLE, CONV, RESP)
//   bin2gray()          : single-cycle binary->Gray, on up to MAX_WIDTH bits
// ---------------------------------------------------------------------------
package code_conv_pkg;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  // Widest operand the helper function handles; callers zero-extend and
  // truncate. Zero extension keeps the MSB rule (g[W-1] = b[W-1]) intact.
  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] op);
    return op ^ (op >> 1);
  endfunction

endpackage

// File: rtl/code_conv_rr_arb.sv
// ---------------------------------------------------------------------------
// code_conv_rr_arb
// Combinational round-robin pick: the first asserted request found when
// searching upward from ptr and wrapping at NREQ.
//   req   in  NREQ  pending requests
//   ptr   in  IW    highest-priority index for this search
//   en    in  1     when low, no grant is produced
//   grant out NREQ  one-hot (or zero) grant
//   idx   out IW    encoded index of the granted request (0 when none)
// ---------------------------------------------------------------------------
module code_conv_rr_arb
  import code_conv_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  logic          found;
  logic [IW:0]   sum;   // one extra bit so ptr + offset cannot overflow before the wrap
  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int o = 0; o < NREQ; o++) begin
      sum = {1'b0, ptr} + (IW+1)'(o);
      if (sum >= (IW+1)'(NREQ)) begin
        sum = sum - (IW+1)'(NREQ);
      end
      cand = sum[IW-1:0];
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/code_conv_arbiter.sv
// ---------------------------------------------------------------------------
// code_conv_arbiter
// Shares one binary<->Gray conversion engine between NREQ requesters.
// Binary->Gray takes one CONV cycle; Gray->binary resolves one bit per
// cycle, MSB first. One operation in flight; result returned with the
// owner's id on a valid/ready response port.
//   clk        in   1            rising-edge clock
//   rst        in   1            asynchronous active-high reset
//   req_valid  in   NREQ         request pending per requester
//   req_ready  out  NREQ         one-hot grant, only in IDLE
//   req_mode   in   NREQ         0 = bin->Gray, 1 = Gray->bin
//   req_data   in   NREQ*WIDTH   operand of requester i at [i*WIDTH +: WIDTH]
//   rsp_valid  out  1            result available (state RESP)
//   rsp_ready  in   1            consumer accepts result
//   rsp_data   out  WIDTH        converted value
//   rsp_id     out  IW           owner of rsp_data
//   busy       out  1            engine not IDLE
// ---------------------------------------------------------------------------
module code_conv_arbiter
  import code_conv_pkg::*;
#(
  parameter  int WIDTH = 4,   // 2 .. MAX_WIDTH
  parameter  int NREQ  = 2,   // >= 2
  localparam int IW    = $clog2(NREQ),
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_mode,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IW-1:0]         rsp_id,
  output logic                  busy
);

  state_t           state_reg, state_next;
  logic [IW-1:0]    ptr_reg,   ptr_next;
  logic [IW-1:0]    id_reg,    id_next;
  logic [CW-1:0]    cnt_reg,   cnt_next;
  logic [WIDTH-1:0] op_reg,    op_next;
  logic [WIDTH-1:0] res_reg,   res_next;
  logic             mode_reg,  mode_next;

  logic [NREQ-1:0]  grant;
  logic [IW-1:0]    grant_idx;
  logic             arb_en;
  logic             accept;
  logic [WIDTH-1:0] res_shr;
  logic [WIDTH-1:0] req_op [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_op[gi] = req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Gating with rst keeps req_ready low while reset is held, even though the
  // state register already reads IDLE.
  assign arb_en = (state_reg == IDLE) && !rst;

  code_conv_rr_arb #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .en    (arb_en),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);

  // res_shr[k] = res[k+1], with 0 above the MSB, so bit k of the Gray->bin
  // result is simply g[k] ^ res_shr[k] whatever k is.
  assign res_shr = res_reg >> 1;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    id_next    = id_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    res_next   = res_reg;
    mode_next  = mode_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          op_next    = req_op[grant_idx];
          mode_next  = req_mode[grant_idx];
          id_next    = grant_idx;
          ptr_next   = (grant_idx == IW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
          cnt_next   = CW'(WIDTH-1);
          res_next   = '0;
          state_next = CONV;
        end
      end
      CONV: begin
        if (mode_reg == MODE_B2G) begin
          res_next   = WIDTH'(bin2gray(MAX_WIDTH'(op_reg)));
          state_next = RESP;
        end else begin
          res_next[cnt_reg] = op_reg[cnt_reg] ^ res_shr[cnt_reg];
          if (cnt_reg == '0) begin
            state_next = RESP;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      id_reg    <= '0;
      cnt_reg   <= '0;
      op_reg    <= '0;
      res_reg   <= '0;
      mode_reg  <= MODE_B2G;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      id_reg    <= id_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      res_reg   <= res_next;
      mode_reg  <= mode_next;
    end
  end

  assign rsp_valid = (state_reg == RESP);
  assign rsp_data  = res_reg;
  assign rsp_id    = id_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_code_conv_arbiter.sv
// ---------------------------------------------------------------------------
// tb_code_conv_arbiter
// Directed bench for code_conv_arbiter (WIDTH = 4, NREQ = 2). Inputs are
// driven just after the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_code_conv_arbiter;

  localparam int WIDTH = 4;
  localparam int NREQ  = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_mode;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [0:0]            rsp_id;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  code_conv_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mode  (req_mode),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Advance until rsp_valid is seen or maxc cycles elapse; lat = cycles waited.
  task automatic wait_rsp(input int maxc, output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < maxc) begin
      tick();
      lat++;
    end
    check("rsp_seen", rsp_valid, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    int         w;
    logic [1:0] exp_g;
    logic       saw_valid;

    rst       = 1'b1;
    req_valid = 2'b11;
    req_mode  = 2'b00;
    req_data  = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_data", rsp_data, 4'b0000);
    check("rst_rsp_id", rsp_id, 1'b0);

    // Bin->Gray on req 0, both requesters valid: first grant goes to req 0.
    req_data = {4'b0000, 4'b1011};
    rst = 1'b0;
    #1;
    check("first_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    check("b2g_busy", busy, 1'b1);
    check("b2g_no_early_rsp", rsp_valid, 1'b0);
    wait_rsp(10, lat);
    $display("b2g: req0 data=1011 -> rsp_data=%b id=%0d latency=%0d", rsp_data, rsp_id, lat + 1);
    check("b2g_latency", lat + 1, 2);
    check("b2g_data", rsp_data, 4'b1110);
    check("b2g_id", rsp_id, 1'b0);
    check("b2g_no_grant_resp", req_ready, 2'b00);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("b2g_rsp_drop", rsp_valid, 1'b0);
    check("b2g_idle", busy, 1'b0);

    // Gray->bin on req 1.
    req_mode  = 2'b10;
    req_data  = {4'b1110, 4'b0000};
    req_valid = 2'b10;
    #1;
    check("g2b_grant", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    wait_rsp(12, lat);
    $display("g2b: req1 data=1110 -> rsp_data=%b id=%0d latency=%0d", rsp_data, rsp_id, lat + 1);
    check("g2b_latency", lat + 1, 5);
    check("g2b_data", rsp_data, 4'b1011);
    check("g2b_id", rsp_id, 1'b1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("g2b_rsp_drop", rsp_valid, 1'b0);

    // Continuous contention: grants must alternate 0,1,0,1.
    req_mode  = 2'b00;
    req_data  = {4'b0110, 4'b0011};
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1;
      w = 0;
      while (req_ready === 2'b00 && w < 5) begin
        tick();
        w++;
      end
      exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
      check("rr_onehot", $countones(req_ready), 1);
      check("rr_grant", req_ready, exp_g);
      tick();
      check("rr_no_grant_conv", req_ready, 2'b00);
      wait_rsp(10, lat);
      $display("rr: op %0d grant=%b rsp_id=%0d rsp_data=%b", n, exp_g, rsp_id, rsp_data);
      check("rr_id", rsp_id, n % 2);
      check("rr_data", rsp_data, (n % 2 == 1) ? 4'b0101 : 4'b0010);
      check("rr_no_grant_hs", req_ready, 2'b00);
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 1'b0;

    // Back-pressure: rsp held 3 cycles, handshake on the 4th.
    req_data  = {4'b0000, 4'b1000};
    req_valid = 2'b01;
    #1;
    check("bp_grant", req_ready, 2'b01);
    tick();
    wait_rsp(10, lat);
    check("bp_data", rsp_data, 4'b1100);
    check("bp_id", rsp_id, 1'b0);
    check("bp_no_grant_0", req_ready, 2'b00);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("bp_valid_hold", rsp_valid, 1'b1);
      check("bp_data_hold", rsp_data, 4'b1100);
      check("bp_id_hold", rsp_id, 1'b0);
      check("bp_no_grant", req_ready, 2'b00);
    end
    tick();
    rsp_ready = 1'b1;
    #1;
    check("bp_hs_valid", rsp_valid, 1'b1);
    check("bp_hs_no_grant", req_ready, 2'b00);
    tick();
    $display("bp: handshake done, rsp_valid=%b busy=%b req_ready=%b", rsp_valid, busy, req_ready);
    check("bp_after_valid", rsp_valid, 1'b0);
    check("bp_after_busy", busy, 1'b0);
    check("bp_after_grant", req_ready, 2'b01);
    req_valid = 2'b00;
    rsp_ready = 1'b0;

    // Reset during the 2nd CONV cycle of a Gray->bin on req 1.
    req_mode  = 2'b10;
    req_data  = {4'b1110, 4'b0000};
    req_valid = 2'b10;
    #1;
    check("abort_grant", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    check("abort_busy_conv", busy, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_req_ready", req_ready, 2'b00);
    check("abort_rsp_data", rsp_data, 4'b0000);
    check("abort_rsp_id", rsp_id, 1'b0);
    tick();
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      saw_valid = saw_valid | (rsp_valid === 1'b1);
    end
    check("abort_no_orphan", saw_valid, 1'b0);
    check("abort_idle", busy, 1'b0);
    req_valid = 2'b11;
    #1;
    $display("abort: after reset req_ready=%b busy=%b", req_ready, busy);
    check("abort_ptr_zero", req_ready, 2'b01);
    req_valid = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
